// File: rtl/byang_host_link.sv
// Host-side initiator for the byte-serial modular-inverse pin protocol.
// Writes a 256-bit operand as 32 strobed bytes, polls valid, reads 32 result bytes back.
module byang_host_link #(
  parameter int PULSE_CYC   = 2,
  parameter int GAP_CYC     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [255:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [255:0] rsp_data,
  output logic         rsp_err,
  output logic [7:0]   bus_data_out,
  output logic         bus_wr,
  output logic         bus_rd,
  input  logic [7:0]   bus_data_in,
  input  logic         dev_ready,
  input  logic         dev_valid
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_HI, WR_LO, SETTLE, POLL, RD_WAIT, RD_HI, RD_LO, RESP
  } state_t;

  state_t             state_q, state_d;
  logic [255:0]       tx_sh_q, tx_sh_d;
  logic [255:0]       rx_sh_q, rx_sh_d;
  logic [4:0]         byte_idx_q, byte_idx_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               err_q, err_d;
  logic               bus_wr_q, bus_wr_d;
  logic               bus_rd_q, bus_rd_d;
  logic [SYNC_STAGES-1:0] rdy_sync_q, vld_sync_q;

  logic               ready_s, valid_s;
  logic [15:0]        cnt_inc;
  logic [4:0]         idx_inc;
  logic [TMR_W-1:0]   tmr_inc;

  assign ready_s = rdy_sync_q[SYNC_STAGES-1];
  assign valid_s = vld_sync_q[SYNC_STAGES-1];

  // All counters saturate rather than wrap.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign idx_inc = (byte_idx_q == 5'd31) ? byte_idx_q : byte_idx_q + 5'd1;
  assign tmr_inc = (tmr_q == TMR_W'(TIMEOUT_CYC)) ? tmr_q : tmr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    byte_idx_d = byte_idx_q;
    cnt_d      = cnt_inc;
    tmr_d      = tmr_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Only start while the device sits in LOAD or READ.
        if (req_valid && (ready_s || valid_s)) begin
          tx_sh_d    = req_data;
          rx_sh_d    = '0;
          byte_idx_d = '0;
          err_d      = 1'b0;
          state_d    = WR_SETUP;
        end
      end
      WR_SETUP: begin
        cnt_d   = '0;
        state_d = WR_HI;
      end
      WR_HI: if (cnt_q == 16'(PULSE_CYC - 1)) begin
        cnt_d   = '0;
        state_d = WR_LO;
      end
      WR_LO: if (cnt_q == 16'(GAP_CYC - 1)) begin
        cnt_d      = '0;
        tx_sh_d    = {tx_sh_q[247:0], 8'h00};
        byte_idx_d = idx_inc;
        state_d    = (byte_idx_q == 5'd31) ? SETTLE : WR_SETUP;
      end
      SETTLE: if (cnt_q == 16'(SETTLE_CYC - 1)) begin
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = POLL;
      end
      POLL: begin
        tmr_d = tmr_inc;
        if (valid_s) begin
          cnt_d      = '0;
          byte_idx_d = '0;
          state_d    = RD_WAIT;
        end else if (tmr_inc == TMR_W'(TIMEOUT_CYC)) begin
          err_d   = 1'b1;
          rx_sh_d = '0;
          state_d = RESP;
        end
      end
      RD_WAIT: if (cnt_q == 16'(SETTLE_CYC - 1)) begin
        cnt_d   = '0;
        rx_sh_d = {rx_sh_q[247:0], bus_data_in};
        if (byte_idx_q == 5'd31) begin
          state_d = RESP;
        end else begin
          byte_idx_d = idx_inc;
          state_d    = RD_HI;
        end
      end
      RD_HI: if (cnt_q == 16'(PULSE_CYC - 1)) begin
        cnt_d   = '0;
        state_d = RD_LO;
      end
      RD_LO: if (cnt_q == 16'(GAP_CYC - 1)) begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RESP: begin
        cnt_d = '0;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are registered copies of the next state, so they cannot glitch.
    bus_wr_d = (state_d == WR_HI);
    bus_rd_d = (state_d == RD_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      byte_idx_q <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
      bus_wr_q   <= 1'b0;
      bus_rd_q   <= 1'b0;
      rdy_sync_q <= '0;
      vld_sync_q <= '0;
    end else begin
      state_q       <= state_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      byte_idx_q    <= byte_idx_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      err_q         <= err_d;
      bus_wr_q      <= bus_wr_d;
      bus_rd_q      <= bus_rd_d;
      rdy_sync_q[0] <= dev_ready;
      vld_sync_q[0] <= dev_valid;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rdy_sync_q[i] <= rdy_sync_q[i-1];
        vld_sync_q[i] <= vld_sync_q[i-1];
      end
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_data     = (state_q == RESP) ? rx_sh_q : '0;
  assign rsp_err      = (state_q == RESP) && err_q;
  assign bus_wr       = bus_wr_q;
  assign bus_rd       = bus_rd_q;
  assign bus_data_out = (state_q inside {WR_SETUP, WR_HI, WR_LO}) ? tx_sh_q[255:248] : 8'h00;

endmodule
